test_status_unit: RTL and testbench
===================================

# test_status_unit

Simulation/FPGA test-status block that sits on the CPU's data-memory write bus, alongside the data memory. It watches stores to a dedicated "tohost" address and decodes them into pass/fail/progress events. It runs a cycle watchdog and raises sticky `done`/`pass`/`fail`/`timeout` flags. Testbenches and board LEDs use these flags instead of probing register-file or RAM internals.

## Interface
Parameters:
- `TOHOST_ADDR`, default `32'h0000_0054`: byte address decoded as the status register.
- `TIMEOUT_CYCLES`, default `1000`: run-cycle limit before timeout. Must be at least 1.
- `HALT_CYCLES`, default `8`: consecutive unchanged-PC cycles that count as a halt. Used only with `STATUS_HALT_DETECT_EN`.

Ports:
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state.
- `MemWrite` input, 1 bit: CPU store strobe. Valid for one cycle per store.
- `DataAdr` input, 32 bits: store byte address.
- `WriteData` input, 32 bits: store data.
- `PC` input, 32 bits: current fetch PC. Ignored without `STATUS_HALT_DETECT_EN`.
- `done` output, 1 bit: the block is in any terminal state.
- `pass` output, 1 bit: test passed.
- `fail` output, 1 bit: test failed.
- `timeout` output, 1 bit: watchdog expired.
- `halted` output, 1 bit: halt detected. Tied 0 without the macro.
- `fail_code` output, 32 bits: `{1'b0, WriteData[31:1]}` from the failing store.
- `last_marker` output, 32 bits: most recent progress marker value.
- `marker_count` output, 16 bits: number of progress markers, saturating at `16'hFFFF`.
- `cycle_count` output, 32 bits: cycles spent in RUN, saturating.

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT, HALT. Reset enters RUN.
- Tohost hit: `MemWrite && DataAdr == TOHOST_ADDR`, compared on the full 32 bits. Only evaluated in RUN.
- Decode of `WriteData` on a hit:
  - `== 32'd1`: go to PASS.
  - bit0 = 1 and value ≠ 1: go to FAIL. Latch `fail_code = WriteData >> 1`.
  - bit0 = 0: progress marker. Set `last_marker = WriteData`, increment `marker_count`, stay in RUN. A value of 0 is a valid marker.
- Watchdog: `cycle_count` increments every RUN cycle. When the pre-increment value equals `TIMEOUT_CYCLES - 1`, go to TIMEOUT.
- Terminal states (PASS, FAIL, TIMEOUT, HALT) are sticky until `reset`. Further stores are ignored. Counters freeze.
- Flag outputs decode the state directly:
  - `pass` = (state == PASS), `fail` = (state == FAIL), `timeout` = (state == TIMEOUT), `halted` = (state == HALT).
  - `done` = OR of the four flags.
- Priority within one cycle: tohost hit, then watchdog, then halt detect.
  - A PASS or FAIL store on the timeout cycle wins.
  - A marker store on the timeout cycle is recorded, and the block still goes to TIMEOUT.
- Stores to any other address have no effect.

## Timing
- Reset values: all flags 0, `fail_code` 0, `last_marker` 0, `marker_count` 0, `cycle_count` 0, state RUN.
- Asserting `reset` mid-run or in a terminal state clears everything asynchronously. RUN resumes on the first edge after deassertion.
- All outputs are registered. A hit sampled at edge N is visible after edge N, i.e. one-cycle latency.
- With `TIMEOUT_CYCLES = T` and no hits, `timeout` rises after the T-th rising edge following reset release. At that point `cycle_count = T`.
- No handshake and no backpressure: every cycle with `MemWrite` high is one independent store.

## Configuration
- `STATUS_HALT_DETECT_EN` defined:
  - Register previous PC and run a consecutive-equal counter. The counter resets on any PC change.
  - When the count reaches `HALT_CYCLES` in RUN, go to HALT. This catches branch-to-self.
- Not defined: `PC` is unused, `halted` is constant 0, and the HALT state is unreachable. No halt logic is synthesized.

## Structure
- Package `status_pkg` holds:
  - the state enum `status_state_t`;
  - constants `STATUS_PASS_VALUE = 32'd1` and `STATUS_FAIL_BIT = 0`.
- Sub-module `sat_counter` (parameterised width, enable, saturating, async reset). It is instantiated for `cycle_count`, `marker_count` and the halt counter.

## Test plan
- Reset, then a store to 0x54 with value 1 at cycle 20 -> `pass` = `done` = 1 one cycle later, and `cycle_count` = 20 frozen.
- Store of value 7 to 0x54 -> `fail` = 1, `fail_code` = 3. A later store of value 1 to 0x54 leaves the flags unchanged.
- Stores of values 4, 0 and 10 to 0x54, plus a store of value 1 to 0x58 -> `marker_count` = 3, `last_marker` = 10, no flags set.
- No stores, `TIMEOUT_CYCLES = 1000` -> `timeout` rises exactly 1000 cycles after reset release. A second run places a store of value 1 on cycle 1000 -> `pass` wins.
- `reset` pulsed while in FAIL -> all outputs 0 asynchronously. The next store of value 1 to 0x54 gives `pass`.
- With `STATUS_HALT_DETECT_EN`, PC held at 0x40 for 8 cycles -> `halted` = 1. Without the macro, the same stimulus leaves `halted` at 0 and the run ends by timeout.

Source files
------------

// File: rtl/status_pkg.sv
// Shared types and constants for the test-status unit.
package status_pkg;

    // Run state plus the four sticky terminal states
    typedef enum logic [2:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_HALT
    } status_state_t;

    // Store value that reports a passing test
    localparam logic [31:0] STATUS_PASS_VALUE = 32'd1;

    // Odd values other than the pass value report a failure
    localparam int STATUS_FAIL_BIT = 0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/test_status_unit.sv
// Test-status unit: decodes stores to the tohost address into pass/fail/
// progress events and runs a cycle watchdog. All flags are sticky until reset.
// Optional halt detection (branch-to-self) is built when the macro
// STATUS_HALT_DETECT_EN is defined; otherwise PC is ignored and halted is 0.
module test_status_unit
    import status_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0054,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          HALT_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic [31:0] PC,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic        halted,
    output logic [31:0] fail_code,
    output logic [31:0] last_marker,
    output logic [15:0] marker_count,
    output logic [31:0] cycle_count
);

    // Pre-increment watchdog value on which the run expires
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    status_state_t state_q;
    status_state_t state_d;

    logic in_run;
    logic hit;
    logic pass_store;
    logic fail_store;
    logic marker_store;
    logic watchdog_expired;
    logic halt_detect;

    assign in_run           = (state_q == ST_RUN);
    assign hit              = in_run && MemWrite && (DataAdr == TOHOST_ADDR);
    assign pass_store       = hit && (WriteData == STATUS_PASS_VALUE);
    assign fail_store       = hit && WriteData[STATUS_FAIL_BIT] && !pass_store;
    assign marker_store     = hit && !WriteData[STATUS_FAIL_BIT];
    assign watchdog_expired = in_run && (cycle_count == TIMEOUT_LAST);

    // Watchdog counter: counts every cycle spent in RUN
    sat_counter #(.WIDTH(32)) u_cycle_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (in_run),
        .count  (cycle_count)
    );

    // Progress marker counter: one per even-valued tohost store
    sat_counter #(.WIDTH(16)) u_marker_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .enable (marker_store),
        .count  (marker_count)
    );

`ifdef STATUS_HALT_DETECT_EN
    localparam logic [15:0] HALT_LAST = 16'(HALT_CYCLES - 1);

    logic [31:0] prev_pc;
    logic        pc_same;
    logic [15:0] halt_count;

    assign pc_same = (PC == prev_pc);

    // Remember last cycle's PC so a stuck fetch address can be spotted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc <= '0;
        end else begin
            prev_pc <= PC;
        end
    end

    // Consecutive-unchanged-PC counter, restarted by any PC change
    sat_counter #(.WIDTH(16)) u_halt_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (!pc_same),
        .enable (in_run && pc_same),
        .count  (halt_count)
    );

    assign halt_detect = in_run && pc_same && (halt_count == HALT_LAST);
    assign halted      = (state_q == ST_HALT);
`else
    logic unused_halt_inputs;

    assign unused_halt_inputs = ^{PC, 32'(HALT_CYCLES)};
    assign halt_detect        = 1'b0;
    assign halted             = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a tohost verdict beats the watchdog, which beats halt
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (pass_store) begin
                state_d = ST_PASS;
            end else if (fail_store) begin
                state_d = ST_FAIL;
            end else if (watchdog_expired) begin
                state_d = ST_TIMEOUT;
            end else if (halt_detect) begin
                state_d = ST_HALT;
            end
        end
    end

    // Latch the failure code and the latest progress marker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_code   <= '0;
            last_marker <= '0;
        end else begin
            if (fail_store) begin
                fail_code <= {1'b0, WriteData[31:1]};
            end
            if (marker_store) begin
                last_marker <= WriteData;
            end
        end
    end

    assign pass    = (state_q == ST_PASS);
    assign fail    = (state_q == ST_FAIL);
    assign timeout = (state_q == ST_TIMEOUT);
    assign done    = pass || fail || timeout || halted;

endmodule

// File: tb/tb_test_status_unit.sv
// Self-checking bench for test_status_unit: a reference model predicts the
// outputs after each store and a scoreboard queue carries the predictions.
module tb_test_status_unit;

    localparam int          T      = 1000;
    localparam logic [31:0] TOHOST = 32'h0000_0054;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic        timeout;
        logic        done;
        logic [31:0] fail_code;
        logic [31:0] last_marker;
        logic [15:0] marker_count;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] PC = '0;
    logic        done, pass, fail, timeout, halted;
    logic [31:0] fail_code, last_marker, cycle_count;
    logic [15:0] marker_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 run, 1 pass, 2 fail, 3 timeout
    int          m_state;
    logic [31:0] m_fail_code;
    logic [31:0] m_last_marker;
    logic [15:0] m_marker_count;
    logic [31:0] m_cycles;
    logic [31:0] pc_val;
    bit          hold_pc;

    snap_t exp_q[$];
    snap_t obs;
    snap_t exp_s;

    test_status_unit #(
        .TOHOST_ADDR    (TOHOST),
        .TIMEOUT_CYCLES (T),
        .HALT_CYCLES    (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .PC           (PC),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .halted       (halted),
        .fail_code    (fail_code),
        .last_marker  (last_marker),
        .marker_count (marker_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    function automatic snap_t model_snap();
        snap_t s;
        s.pass         = (m_state == 1);
        s.fail         = (m_state == 2);
        s.timeout      = (m_state == 3);
        s.done         = (m_state != 0);
        s.fail_code    = m_fail_code;
        s.last_marker  = m_last_marker;
        s.marker_count = m_marker_count;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.pass         = pass;
        s.fail         = fail;
        s.timeout      = timeout;
        s.done         = done;
        s.fail_code    = fail_code;
        s.last_marker  = last_marker;
        s.marker_count = marker_count;
        return s;
    endfunction

    task automatic model_clear();
        m_state        = 0;
        m_fail_code    = '0;
        m_last_marker  = '0;
        m_marker_count = '0;
        m_cycles       = '0;
        pc_val         = 32'h0000_1000;
        hold_pc        = 1'b0;
        exp_q.delete();
    endtask

    // Hold reset across one edge, then release it just after the edge
    task automatic do_reset();
        reset    = 1'b1;
        MemWrite = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Drive one cycle of bus activity, advance the model, optionally queue
    // the predicted outputs, then step past the rising edge
    task automatic cycle(input logic we, input logic [31:0] addr,
                         input logic [31:0] data, input bit push);
        logic [31:0] pre;
        MemWrite  = we;
        DataAdr   = addr;
        WriteData = data;
        PC        = hold_pc ? 32'h0000_0040 : pc_val;
        pc_val    = pc_val + 32'd4;
        if (m_state == 0) begin
            pre      = m_cycles;
            m_cycles = m_cycles + 32'd1;
            if (we && addr == TOHOST && data == 32'd1) begin
                m_state = 1;
            end else if (we && addr == TOHOST && data[0]) begin
                m_state     = 2;
                m_fail_code = data >> 1;
            end else begin
                if (we && addr == TOHOST) begin
                    m_last_marker  = data;
                    m_marker_count = m_marker_count + 16'd1;
                end
                if (pre == 32'(T - 1)) m_state = 3;
            end
        end
        if (push) exp_q.push_back(model_snap());
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        #2;
        n_checks++;
        if (dut_snap() !== snap_t'(0)) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", dut_snap(), snap_t'(0));
        end
        n_checks++;
        if (cycle_count !== 32'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: got cycle_count=%0d halted=%b expected 0/0", cycle_count, halted);
        end
    endtask

    task automatic test_pass();
        do_reset();
        idle(19);
        cycle(1'b1, TOHOST, 32'd1, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL pass_store: got %h expected %h", obs, exp_s);
        end
        n_checks++;
        if (cycle_count !== 32'd20) begin
            n_fail++;
            $display("[TB] FAIL pass_cycle_count: got %0d expected 20", cycle_count);
        end
        idle(5);
        n_checks++;
        if (cycle_count !== 32'd20 || pass !== 1'b1 || done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pass_frozen: got cycle_count=%0d pass=%b done=%b expected 20/1/1", cycle_count, pass, done);
        end
    endtask

    task automatic test_fail();
        do_reset();
        idle(3);
        cycle(1'b1, TOHOST, 32'd7, 1'b1);
        cycle(1'b1, TOHOST, 32'd1, 1'b1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL fail_queue: got empty expected entry %0d", k);
            end else begin
                exp_s = exp_q.pop_front();
                obs   = dut_snap();
                if (obs !== exp_s) begin
                    n_fail++;
                    $display("[TB] FAIL fail_sticky_%0d: got %h expected %h", k, obs, exp_s);
                end
            end
        end
        n_checks++;
        if (fail_code !== 32'd3 || pass !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fail_code: got code=%0d pass=%b expected 3/0", fail_code, pass);
        end
    endtask

    task automatic test_markers();
        logic [31:0] vals [4] = '{32'd4, 32'd0, 32'd10, 32'd1};
        logic [31:0] adrs [4] = '{TOHOST, TOHOST, TOHOST, 32'h0000_0058};
        snap_t got [4];
        do_reset();
        idle(2);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, adrs[k], vals[k], 1'b1);
            got[k] = dut_snap();
        end
        for (int k = 0; k < 4; k++) begin
            exp_s = exp_q.pop_front();
            n_checks++;
            if (got[k] !== exp_s) begin
                n_fail++;
                $display("[TB] FAIL marker_%0d: got %h expected %h", k, got[k], exp_s);
            end
        end
        n_checks++;
        if (marker_count !== 16'd3 || last_marker !== 32'd10 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL marker_final: got count=%0d last=%0d done=%b expected 3/10/0", marker_count, last_marker, done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1'b1, TOHOST, 32'd2, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got %h expected %h", obs, exp_s);
        end
        cycle(1'b1, TOHOST, 32'd4, 1'b1);
        cycle(1'b1, TOHOST, 32'd5, 1'b1);
        void'(exp_q.pop_front());
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL b2b_fail: got %h expected %h", obs, exp_s);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        idle(T - 1);
        n_checks++;
        if (timeout !== 1'b0 || cycle_count !== 32'(T - 1)) begin
            n_fail++;
            $display("[TB] FAIL timeout_early: got timeout=%b count=%0d expected 0/%0d", timeout, cycle_count, T - 1);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s || cycle_count !== 32'(T)) begin
            n_fail++;
            $display("[TB] FAIL timeout_edge: got %h count=%0d expected %h count=%0d", obs, cycle_count, exp_s, T);
        end
    endtask

    task automatic test_timeout_race();
        do_reset();
        idle(T - 1);
        cycle(1'b1, TOHOST, 32'd1, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL race_pass: got %h expected %h", obs, exp_s);
        end
        do_reset();
        idle(T - 1);
        cycle(1'b1, TOHOST, 32'd6, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL race_marker: got %h expected %h", obs, exp_s);
        end
    endtask

    task automatic test_reset_in_fail();
        do_reset();
        idle(4);
        cycle(1'b1, TOHOST, 32'd9, 1'b1);
        exp_s = exp_q.pop_front();
        n_checks++;
        if (dut_snap() !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL prereset_fail: got %h expected %h", dut_snap(), exp_s);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut_snap() !== snap_t'(0) || cycle_count !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h count=%0d expected 0", dut_snap(), cycle_count);
        end
        do_reset();
        cycle(1'b1, TOHOST, 32'd1, 1'b1);
        obs = dut_snap();
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL post_reset_pass: got %h expected %h", obs, exp_s);
        end
    endtask

    task automatic test_halt();
        int waited;
        do_reset();
        hold_pc = 1'b1;
`ifdef STATUS_HALT_DETECT_EN
        waited = 0;
        while (halted !== 1'b1 && waited < 20) begin
            idle(1);
            waited++;
        end
        n_checks++;
        if (halted !== 1'b1 || done !== 1'b1 || timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL halt_detect: got halted=%b done=%b timeout=%b expected 1/1/0", halted, done, timeout);
        end
`else
        idle(20);
        n_checks++;
        if (halted !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL halt_disabled: got halted=%b done=%b expected 0/0", halted, done);
        end
        waited = 20;
        while (timeout !== 1'b1 && waited < T + 10) begin
            idle(1);
            waited++;
        end
        n_checks++;
        if (timeout !== 1'b1 || halted !== 1'b0 || waited != T) begin
            n_fail++;
            $display("[TB] FAIL halt_disabled_timeout: got timeout=%b halted=%b cycles=%0d expected 1/0/%0d", timeout, halted, waited, T);
        end
`endif
        hold_pc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_markers();
        test_back_to_back();
        test_timeout();
        test_timeout_race();
        test_reset_in_fail();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
